// File: rtl/gate_bist_pkg.sv
// Shared types and golden model for the 2-input logic unit self-test.
// State encoding, vector count and the expected {and,or,xor} response.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_VEC = 4;

  function automatic logic [2:0] gate_expect(
    input logic a,
    input logic b
  );
    return {a & b, a | b, a ^ b};
  endfunction

endpackage

// File: rtl/gate_bist_cmp.sv
// Combinational response checker: golden truth table vs unit outputs.
// Ports: a, b, y_and, y_or, y_xor in; mismatch out (any bit differs).
module gate_bist_cmp
  import gate_bist_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic y_and,
  input  logic y_or,
  input  logic y_xor,
  output logic mismatch
);

  logic [2:0] exp_y;
  logic [2:0] got_y;

  assign exp_y    = gate_expect(a, b);
  assign got_y    = {y_and, y_or, y_xor};
  assign mismatch = |(exp_y ^ got_y);

endmodule

// File: rtl/gate_bist.sv
// Self-test sequencer: walks {a,b} through 00..11, samples y_* after a
// settle time, reports fail map, error count, pass; busy/done status.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y_and,
  input  logic       y_or,
  input  logic       y_xor,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0] IDX_LAST = 2'(NUM_VEC - 1);

  state_e           state_q;
  state_e           state_d;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             a_q;
  logic             b_q;
  logic [3:0]       fail_q;
  logic [2:0]       err_q;
  logic             pass_q;
  logic             mismatch;
  logic             last_vec;

  assign last_vec = (idx_q == IDX_LAST);

  gate_bist_cmp u_cmp (
    .a        (a_q),
    .b        (b_q),
    .y_and    (y_and),
    .y_or     (y_or),
    .y_xor    (y_xor),
    .mismatch (mismatch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = DRIVE;
      DRIVE:  if (cnt_q == CNT_LAST) state_d = SAMPLE;
      SAMPLE: state_d = last_vec ? DONE : DRIVE;
      DONE:   state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state_q == DRIVE),
      (state_q == SAMPLE): busy = 1'b1;
      (state_q == DONE):   done = 1'b1;
      default:             busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      fail_q <= '0;
      err_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            fail_q <= '0;
            err_q  <= '0;
            pass_q <= 1'b0;
          end
        end
        DRIVE: begin
          cnt_q <= cnt_q + 1'b1;
        end
        SAMPLE: begin
          if (mismatch) begin
            fail_q[idx_q] <= 1'b1;
            err_q         <= err_q + 3'd1;
          end
          if (last_vec) begin
            // Final verdict lands with the last sample so it is
            // already valid during the done cycle.
            pass_q <= (fail_q == 4'd0) && !mismatch;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
          end else begin
            idx_q <= idx_q + 2'd1;
            cnt_q <= '0;
            {a_q, b_q} <= idx_q + 2'd1;
          end
        end
        DONE: begin
          a_q <= 1'b0;
          b_q <= 1'b0;
        end
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign pass      = pass_q;
  assign fail_vec  = fail_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: default and SETTLE_CYCLES=1 instances driving
// a behavioural logic unit with injectable faults and glitches.
module tb_gate_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic       st0 = 1'b0;
  logic       a0, b0, ya0, yo0, yx0;
  logic       busy0, done0, pass0;
  logic [3:0] fv0;
  logic [2:0] ec0;

  logic       st1 = 1'b0;
  logic       a1, b1, ya1, yo1, yx1;
  logic       busy1, done1, pass1;
  logic [3:0] fv1;
  logic [2:0] ec1;

  logic [2:0] m0 [4];
  logic and_inv = 1'b0;
  logic or_st   = 1'b0;
  logic xor_t0  = 1'b0;
  logic gl0     = 1'b0;

  assign ya0 = (a0 & b0) ^ and_inv ^ m0[{a0, b0}][2] ^ gl0;
  assign yo0 = or_st | ((a0 | b0) ^ m0[{a0, b0}][1] ^ gl0);
  assign yx0 = ~xor_t0 & ((a0 ^ b0) ^ m0[{a0, b0}][0] ^ gl0);

  assign ya1 = a1 & b1;
  assign yo1 = a1 | b1;
  assign yx1 = a1 ^ b1;

  gate_bist u0 (
    .clk(clk), .rst_n(rst_n), .start(st0),
    .a(a0), .b(b0),
    .y_and(ya0), .y_or(yo0), .y_xor(yx0),
    .busy(busy0), .done(done0), .pass(pass0),
    .fail_vec(fv0), .err_count(ec0)
  );

  gate_bist #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1),
    .a(a1), .b(b1),
    .y_and(ya1), .y_or(yo1), .y_xor(yx1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_vec(fv1), .err_count(ec1)
  );

  int         r_dcyc;
  logic [1:0] r_ab [4];
  bit         r_busy_bad;
  bit         r_to;
  logic [3:0] r_fv;
  logic [2:0] r_ec;
  logic       r_ps;
  logic       r_bd;

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) st0 = v;
    else st1 = v;
  endtask

  // Runs one sequence and records what the DUT did; no verdicts here.
  task automatic run_seq(input int inst, input bit hold,
                         input bit already, input bit glit,
                         input int pulse_at);
    int e0, rel, per;
    bit seen;
    logic d, bz;
    per = (inst == 0) ? 3 : 2;
    if (!already) begin
      @(negedge clk);
      set_start(inst, 1'b1);
      @(negedge clk);
      if (!hold) set_start(inst, 1'b0);
    end
    e0 = cyc;
    seen = 0;
    r_busy_bad = 0;
    r_to = 0;
    r_dcyc = -1;
    for (int k = 0; k < 4; k++) r_ab[k] = 2'bxx;
    for (int t = 0; t < 60 && !seen; t++) begin
      rel = cyc - e0;
      if (rel % per == 0 && rel / per < 4)
        r_ab[rel / per] = (inst == 0) ? {a0, b0} : {a1, b1};
      if (inst == 0)
        gl0 = glit && (rel % per == 0) && (rel < 4 * per);
      if (pulse_at >= 0)
        set_start(inst, rel == pulse_at - 1);
      d  = (inst == 0) ? done0 : done1;
      bz = (inst == 0) ? busy0 : busy1;
      if (d === 1'b1) begin
        seen   = 1;
        r_dcyc = rel;
        r_fv   = (inst == 0) ? fv0 : fv1;
        r_ec   = (inst == 0) ? ec0 : ec1;
        r_ps   = (inst == 0) ? pass0 : pass1;
        r_bd   = bz;
      end else begin
        if (bz !== 1'b1) r_busy_bad = 1;
        @(negedge clk);
      end
    end
    gl0 = 1'b0;
    if (pulse_at >= 0) set_start(inst, 1'b0);
    if (!seen) r_to = 1;
  endtask

  task automatic test_reset;
    logic [12:0] o0, o1;
    o0 = {a0, b0, busy0, done0, pass0, fv0, ec0};
    o1 = {a1, b1, busy1, done1, pass1, fv1, ec1};
    checks++;
    if (o0 !== 13'd0) begin
      errors++;
      $display("FAIL reset_u0: got %b want 0", o0);
    end
    checks++;
    if (o1 !== 13'd0) begin
      errors++;
      $display("FAIL reset_u1: got %b want 0", o1);
    end
  endtask

  task automatic test_golden;
    run_seq(0, 0, 0, 0, -1);
    checks++;
    if (r_to || r_dcyc !== 12) begin
      errors++;
      $display("FAIL golden_done: got %0d want 12", r_dcyc);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (r_ab[k] !== 2'(k)) begin
        errors++;
        $display("FAIL golden_ab%0d: got %b want %b",
                 k, r_ab[k], 2'(k));
      end
    end
    checks++;
    if (r_busy_bad || r_bd !== 1'b0) begin
      errors++;
      $display("FAIL golden_busy: got bad=%0d bd=%b want 0/0",
               r_busy_bad, r_bd);
    end
    checks++;
    if ({r_ps, r_fv, r_ec} !== {1'b1, 4'd0, 3'd0}) begin
      errors++;
      $display("FAIL golden_res: got p=%b f=%b e=%0d want 1/0/0",
               r_ps, r_fv, r_ec);
    end
  endtask

  task automatic test_xor_tied;
    xor_t0 = 1'b1;
    run_seq(0, 0, 0, 0, -1);
    xor_t0 = 1'b0;
    checks++;
    if (r_to || {r_ps, r_fv, r_ec} !== {1'b0, 4'b0110, 3'd2}) begin
      errors++;
      $display("FAIL xor_tied: got p=%b f=%b e=%0d want 0/0110/2",
               r_ps, r_fv, r_ec);
    end
  endtask

  task automatic test_and_inv;
    and_inv = 1'b1;
    run_seq(0, 0, 0, 0, -1);
    and_inv = 1'b0;
    checks++;
    if (r_to || {r_ps, r_fv, r_ec} !== {1'b0, 4'b1111, 3'd4}) begin
      errors++;
      $display("FAIL and_inv: got p=%b f=%b e=%0d want 0/1111/4",
               r_ps, r_fv, r_ec);
    end
  endtask

  task automatic test_random;
    logic [3:0] efv;
    int eec;
    for (int it = 0; it < 8; it++) begin
      eec = 0;
      for (int k = 0; k < 4; k++) begin
        m0[k] = $urandom_range(0, 1) ? 3'($urandom_range(0, 7)) : 3'd0;
        efv[k] = (m0[k] != 3'd0);
        if (efv[k]) eec++;
      end
      run_seq(0, 0, 0, 1, -1);
      checks++;
      if (r_to || r_dcyc !== 12 || r_fv !== efv ||
          r_ec !== 3'(eec) || r_ps !== (eec == 0)) begin
        errors++;
        $display("FAIL rand%0d: got d=%0d f=%b e=%0d p=%b want 12/%b/%0d/%0d",
                 it, r_dcyc, r_fv, r_ec, r_ps, efv, eec, eec == 0);
      end
    end
    for (int k = 0; k < 4; k++) m0[k] = 3'd0;
  endtask

  task automatic test_settle1;
    run_seq(1, 0, 0, 0, 3);
    checks++;
    if (r_to || r_dcyc !== 8) begin
      errors++;
      $display("FAIL s1_done: got %0d want 8", r_dcyc);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (r_ab[k] !== 2'(k)) begin
        errors++;
        $display("FAIL s1_ab%0d: got %b want %b", k, r_ab[k], 2'(k));
      end
    end
    checks++;
    if (r_busy_bad || {r_ps, r_fv, r_ec} !== {1'b1, 4'd0, 3'd0}) begin
      errors++;
      $display("FAIL s1_res: got bb=%0d p=%b f=%b e=%0d want 0/1/0/0",
               r_busy_bad, r_ps, r_fv, r_ec);
    end
  endtask

  task automatic test_reset_mid;
    int e0;
    logic [12:0] o0;
    m0[0] = 3'b001;
    @(negedge clk);
    st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    e0 = cyc;
    while (cyc - e0 < 7) @(negedge clk);
    checks++;
    if ({a0, b0, busy0, fv0} !== {2'b10, 1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL mid_pre: got ab=%b%b bz=%b f=%b want 10/1/0001",
               a0, b0, busy0, fv0);
    end
    rst_n = 1'b0;
    #1;
    o0 = {a0, b0, busy0, done0, pass0, fv0, ec0};
    checks++;
    if (o0 !== 13'd0) begin
      errors++;
      $display("FAIL mid_rst: got %b want 0", o0);
    end
    m0[0] = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({a0, b0, busy0, done0} !== 4'd0) begin
      errors++;
      $display("FAIL mid_idle: got %b want 0000",
               {a0, b0, busy0, done0});
    end
    run_seq(0, 0, 0, 0, -1);
    checks++;
    if (r_to || {r_ps, r_fv, r_ec} !== {1'b1, 4'd0, 3'd0}) begin
      errors++;
      $display("FAIL mid_rerun: got p=%b f=%b e=%0d want 1/0/0",
               r_ps, r_fv, r_ec);
    end
  endtask

  task automatic test_back_to_back;
    or_st = 1'b1;
    run_seq(0, 1, 0, 0, -1);
    or_st = 1'b0;
    checks++;
    if (r_to || {r_ps, r_fv, r_ec} !== {1'b0, 4'b0001, 3'd1}) begin
      errors++;
      $display("FAIL b2b_run1: got p=%b f=%b e=%0d want 0/0001/1",
               r_ps, r_fv, r_ec);
    end
    @(negedge clk);
    checks++;
    if ({busy0, done0, fv0} !== {2'b00, 4'b0001}) begin
      errors++;
      $display("FAIL b2b_idle: got bz=%b d=%b f=%b want 0/0/0001",
               busy0, done0, fv0);
    end
    @(negedge clk);
    checks++;
    if ({busy0, pass0, fv0, ec0} !== {2'b10, 4'd0, 3'd0}) begin
      errors++;
      $display("FAIL b2b_clear: got bz=%b p=%b f=%b e=%0d want 1/0/0/0",
               busy0, pass0, fv0, ec0);
    end
    run_seq(0, 1, 1, 0, -1);
    st0 = 1'b0;
    checks++;
    if (r_to || r_dcyc !== 12 ||
        {r_ps, r_fv, r_ec} !== {1'b1, 4'd0, 3'd0}) begin
      errors++;
      $display("FAIL b2b_run2: got d=%0d p=%b f=%b e=%0d want 12/1/0/0",
               r_dcyc, r_ps, r_fv, r_ec);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 4; k++) m0[k] = 3'd0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_golden;
    test_xor_tied;
    test_and_inv;
    test_random;
    test_settle1;
    test_reset_mid;
    test_back_to_back;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
